// File: rtl/hdr_frame_writer.sv
// hdr_frame_writer: packs the RGB565 pixel stream into 256-bit words and writes
// them into a ping-pong pair of HDR frame buffers in DDR.
//   pix_valid/pix_data/pix_last/pix_ready : pixel stream in (16 pixels per word)
//   ram_busy                              : RAM controller stall
//   wr_req/wr_address/wr_data             : one-cycle write request out
//   frame_written                         : pulse with the last word of a frame
//   hdr_last_frame                        : buffer index of last finished frame
//   frame_err                             : sticky frame-length error
module hdr_frame_writer #(
  parameter int          FRAME_WORDS = 19200,
  parameter int          ADDR_STEP   = 8,
  parameter logic [24:0] HDR_BASE    = 25'hE1000,
  parameter logic [24:0] BUF_SPAN    = 25'h25800
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pix_valid,
  input  logic [15:0]  pix_data,
  input  logic         pix_last,
  output logic         pix_ready,
  input  logic         ram_busy,
  output logic         wr_req,
  output logic [24:0]  wr_address,
  output logic [255:0] wr_data,
  output logic         frame_written,
  output logic         hdr_last_frame,
  output logic         frame_err
);
  localparam int IW = $clog2(FRAME_WORDS + 1);
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [255:0]        pack_q, pack_d;
  logic [1:0][255:0]   fdat_q, fdat_d;
  logic [1:0]          flast_q, flast_d;
  logic                wp_q, wp_d, rp_q, rp_d;
  logic [1:0]          occ_q, occ_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                buf_q, buf_d;
  logic                hlf_q, hlf_d;
  logic                ferr_q, ferr_d;
  logic [24:0]         alast_q, alast_d;
  logic [255:0]        dlast_q, dlast_d;
  logic                ends, acc, push, pop, head_last, idx_end;
  logic [255:0]        word, head;
  logic [24:0]         addr;
  always_comb begin
    // a pixel that closes a word needs a free FIFO slot to land in
    ends = cnt_q == 4'd15 || pix_last;
    pix_ready = !rst && !(occ_q == 2'd2 && ends);
    acc = pix_valid && pix_ready;
    push = acc && ends;
    word = pack_q | (256'(pix_data) << {cnt_q, 4'b0000});
    pack_d = acc ? (ends ? '0 : word) : pack_q;
    cnt_d = acc ? (ends ? 4'd0 : cnt_q + 4'd1) : cnt_q;
    head = fdat_q[rp_q];
    head_last = flast_q[rp_q];
    addr = (buf_q ? HDR_BASE + BUF_SPAN : HDR_BASE) + 25'(idx_q) * 25'(ADDR_STEP);
    wr_req = !rst && state_q == ISSUE && !ram_busy;
    pop = wr_req;
    frame_written = wr_req && head_last;
    wr_address = wr_req ? addr : alast_q;
    wr_data = wr_req ? head : dlast_q;
    alast_d = wr_address;
    dlast_d = wr_data;
    idx_end = idx_q == IW'(FRAME_WORDS - 1);
    // an untagged word filling the last slot wraps inside the same buffer
    idx_d = pop ? ((head_last || idx_end) ? '0 : idx_q + 1'b1) : idx_q;
    buf_d = buf_q ^ frame_written;
    hlf_d = frame_written ? buf_q : hlf_q;
    ferr_d = ferr_q | (pop && (head_last ? !idx_end : idx_end));
    fdat_d = fdat_q;
    flast_d = flast_q;
    fdat_d[wp_q] = push ? word : fdat_q[wp_q];
    flast_d[wp_q] = push ? pix_last : flast_q[wp_q];
    wp_d = wp_q ^ push;
    rp_d = rp_q ^ pop;
    occ_d = occ_q + 2'(push) - 2'(pop);
    // IDLE waits one cycle on a registered non-empty FIFO before issuing
    state_d = (state_q == IDLE ? occ_q != 2'd0 : occ_d != 2'd0) ? ISSUE : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pack_q  <= '0;
      fdat_q  <= '0;
      flast_q <= '0;
      wp_q    <= 1'b0;
      rp_q    <= 1'b0;
      occ_q   <= '0;
      idx_q   <= '0;
      buf_q   <= 1'b0;
      hlf_q   <= 1'b0;
      ferr_q  <= 1'b0;
      alast_q <= '0;
      dlast_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pack_q  <= pack_d;
      fdat_q  <= fdat_d;
      flast_q <= flast_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      occ_q   <= occ_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      hlf_q   <= hlf_d;
      ferr_q  <= ferr_d;
      alast_q <= alast_d;
      dlast_q <= dlast_d;
    end
  end
  assign hdr_last_frame = hlf_q;
  assign frame_err = ferr_q;
endmodule

// File: tb/tb_hdr_frame_writer.sv
// tb_hdr_frame_writer: directed bench for hdr_frame_writer with a 4-word frame
module tb_hdr_frame_writer;
  logic         clk = 0, rst = 1, pix_valid = 0, pix_last = 0, ram_busy = 0, tgl = 0;
  logic [15:0]  pix_data = '0;
  logic         pix_ready, wr_req, frame_written, hdr_last_frame, frame_err;
  logic [24:0]  wr_address;
  logic [255:0] wr_data, e;
  logic [24:0]  q_addr[$];
  logic [255:0] q_data[$];
  logic         q_fw[$];
  int           n_chk = 0, n_err = 0;

  hdr_frame_writer #(.FRAME_WORDS(4), .ADDR_STEP(8), .HDR_BASE(25'hE1000), .BUF_SPAN(25'h20)) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_data(pix_data), .pix_last(pix_last),
    .pix_ready(pix_ready), .ram_busy(ram_busy), .wr_req(wr_req), .wr_address(wr_address),
    .wr_data(wr_data), .frame_written(frame_written), .hdr_last_frame(hdr_last_frame),
    .frame_err(frame_err));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk)
    if (wr_req) begin
      q_addr.push_back(wr_address);
      q_data.push_back(wr_data);
      q_fw.push_back(frame_written);
      check("req_busy", 256'(ram_busy), 256'(0));
    end

  task automatic tick;
    @(posedge clk);
    #1;
    if (tgl) ram_busy = ~ram_busy;
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    logic ok;
    pix_valid = 1; pix_data = d; pix_last = l;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      ok = pix_ready;
      tick;
      if (ok) begin
        pix_valid = 0; pix_last = 0;
        return;
      end
    end
    check("send_timeout", 256'(0), 256'(1));
    pix_valid = 0; pix_last = 0;
  endtask

  task automatic send_frame(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) send(base + 16'(i), i == n - 1);
  endtask

  task automatic wait_wr(input int n);
    for (int t = 0; t < 300 && q_addr.size() < n; t++) tick;
    check("wr_count", 256'(q_addr.size()), 256'(n));
  endtask

  task automatic do_reset;
    tgl = 0; pix_valid = 0; pix_last = 0; rst = 1;
    tick;
    rst = 0;
    q_addr.delete(); q_data.delete(); q_fw.delete();
  endtask

  initial begin
    tick; tick;
    @(negedge clk);
    check("rst_ready", 256'(pix_ready), 256'(0));
    check("rst_req", 256'(wr_req), 256'(0));
    check("rst_addr", 256'(wr_address), 256'(0));
    check("rst_data", wr_data, 256'(0));
    check("rst_fw", 256'(frame_written), 256'(0));
    check("rst_hlf", 256'(hdr_last_frame), 256'(0));
    check("rst_ferr", 256'(frame_err), 256'(0));
    do_reset;

    for (int i = 0; i < 16; i++) send(16'(i + 1), 0);
    @(negedge clk);
    check("lat_early", 256'(wr_req), 256'(0));
    @(negedge clk);
    check("lat_req", 256'(wr_req), 256'(1));
    wait_wr(1);
    check("w1_addr", 256'(q_addr[0]), 256'(25'hE1000));
    check("w1_lane0", 256'(q_data[0][15:0]), 256'(16'h0001));
    check("w1_lane15", 256'(q_data[0][255:240]), 256'(16'h0010));
    for (int i = 0; i < 16; i++) e[16*i +: 16] = 16'(i + 1);
    check("w1_word", q_data[0], e);

    do_reset;
    send_frame(16'h1000, 64);
    wait_wr(4);
    for (int k = 0; k < 4; k++) begin
      check("f0_addr", 256'(q_addr[k]), 256'(25'hE1000 + 25'(8 * k)));
      check("f0_fw", 256'(q_fw[k]), 256'(k == 3));
    end
    check("f0_lastpix", 256'(q_data[3][255:240]), 256'(16'h103F));
    check("f0_hlf", 256'(hdr_last_frame), 256'(0));
    check("f0_ferr", 256'(frame_err), 256'(0));
    send_frame(16'h2000, 64);
    wait_wr(8);
    check("f1_first", 256'(q_addr[4]), 256'(25'hE1020));
    check("f1_last", 256'(q_addr[7]), 256'(25'hE1038));
    check("f1_fw", 256'(q_fw[7]), 256'(1));
    check("f1_lane0", 256'(q_data[4][15:0]), 256'(16'h2000));
    check("f1_hlf", 256'(hdr_last_frame), 256'(1));
    check("f1_ferr", 256'(frame_err), 256'(0));

    do_reset;
    ram_busy = 1;
    for (int i = 0; i < 47; i++) send(16'h4000 + 16'(i), 0);
    pix_valid = 1; pix_data = 16'h402F; pix_last = 0;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      check("bp_ready", 256'(pix_ready), 256'(0));
      tick;
    end
    check("bp_noreq", 256'(q_addr.size()), 256'(0));
    ram_busy = 0;
    @(negedge clk);
    check("bp_req0", 256'(wr_req), 256'(1));
    check("bp_addr0", 256'(wr_address), 256'(25'hE1000));
    check("bp_full", 256'(pix_ready), 256'(0));
    @(negedge clk);
    check("bp_req1", 256'(wr_req), 256'(1));
    check("bp_addr1", 256'(wr_address), 256'(25'hE1008));
    check("bp_ready1", 256'(pix_ready), 256'(1));
    @(posedge clk);
    #1 pix_valid = 0;
    wait_wr(3);
    check("bp_addr2", 256'(q_addr[2]), 256'(25'hE1010));
    check("bp_lane15", 256'(q_data[2][255:240]), 256'(16'h402F));

    do_reset;
    send_frame(16'h00A0, 5);
    wait_wr(1);
    e = '0;
    for (int i = 0; i < 5; i++) e[16*i +: 16] = 16'h00A0 + 16'(i);
    check("sh_word", q_data[0], e);
    check("sh_fw", 256'(q_fw[0]), 256'(1));
    check("sh_ferr", 256'(frame_err), 256'(1));
    check("sh_hlf", 256'(hdr_last_frame), 256'(0));

    do_reset;
    ram_busy = 1;
    for (int i = 0; i < 23; i++) send(16'h7000 + 16'(i), 0);
    rst = 1;
    tick;
    rst = 0; ram_busy = 0;
    for (int t = 0; t < 10; t++) tick;
    check("rr_noreq", 256'(q_addr.size()), 256'(0));
    check("rr_ferr", 256'(frame_err), 256'(0));
    for (int i = 0; i < 16; i++) send(16'h0050 + 16'(i), 0);
    wait_wr(1);
    check("rr_addr", 256'(q_addr[0]), 256'(25'hE1000));
    check("rr_lane0", 256'(q_data[0][15:0]), 256'(16'h0050));
    check("rr_lane15", 256'(q_data[0][255:240]), 256'(16'h005F));

    do_reset;
    tgl = 1;
    send_frame(16'h0300, 64);
    wait_wr(4);
    for (int t = 0; t < 10; t++) tick;
    tgl = 0; ram_busy = 0;
    check("tg_count", 256'(q_addr.size()), 256'(4));
    for (int k = 0; k < 4; k++) begin
      check("tg_addr", 256'(q_addr[k]), 256'(25'hE1000 + 25'(8 * k)));
      check("tg_lane0", 256'(q_data[k][15:0]), 256'(16'h0300 + 16'(16 * k)));
    end
    check("tg_fw", 256'(q_fw[3]), 256'(1));
    check("tg_ferr", 256'(frame_err), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
